// File: rtl/max_sched_if.sv
// Bundle between max_sched and its two Q-learning requesters plus the shared max unit.
// The slave modport is the scheduler's view; master is the environment's view.
interface max_sched_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ACTIONS       = 4,
    parameter int unsigned ACTIONS_WIDTH = 2
);
    logic                            a_req;
    logic [DATA_WIDTH*ACTIONS-1:0]   a_data;
    logic                            a_gnt;
    logic                            a_done;
    logic [ACTIONS_WIDTH-1:0]        a_action;
    logic                            a_explore;
    logic                            b_req;
    logic [DATA_WIDTH*ACTIONS-1:0]   b_data;
    logic                            b_gnt;
    logic                            b_done;
    logic [DATA_WIDTH-1:0]           b_qmax;
    logic [7:0]                      epsilon;
    logic                            mx_valid;
    logic [DATA_WIDTH*ACTIONS-1:0]   mx_data;
    logic [DATA_WIDTH-1:0]           mx_max;
    logic [ACTIONS_WIDTH-1:0]        mx_at_max;
    logic                            mx_done;
    logic                            timeout_err;

    modport master (
        output a_req, a_data, b_req, b_data, epsilon, mx_max, mx_at_max, mx_done,
        input  a_gnt, a_done, a_action, a_explore, b_gnt, b_done, b_qmax, mx_valid, mx_data,
               timeout_err
    );

    modport slave (
        input  a_req, a_data, b_req, b_data, epsilon, mx_max, mx_at_max, mx_done,
        output a_gnt, a_done, a_action, a_explore, b_gnt, b_done, b_qmax, mx_valid, mx_data,
               timeout_err
    );
endinterface

// File: rtl/max_sched.sv
// Round-robin sharing of one 4-way max/argmax unit between action selection (A, with
// epsilon-greedy exploration) and target computation (B), with a hung-unit timeout.
module max_sched #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ACTIONS       = 4,
    parameter int unsigned ACTIONS_WIDTH = 2,
    parameter int unsigned TIMEOUT       = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    max_sched_if.slave bus
);
    localparam int unsigned RowW   = DATA_WIDTH * ACTIONS;
    localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Last WAIT cycle is the one where the count would reach TIMEOUT-1.
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 2);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;      // 1 = B
    logic                     rr_last_q, rr_last_d;  // 1 = B
    logic [RowW-1:0]          mx_data_q, mx_data_d;
    logic [TimerW-1:0]        timer_q, timer_d;
    logic [DATA_WIDTH-1:0]    res_max_q, res_max_d;
    logic [ACTIONS_WIDTH-1:0] res_idx_q, res_idx_d;
    logic                     timeout_err_q, timeout_err_d;
    logic [ACTIONS_WIDTH-1:0] a_action_q, a_action_d;
    logic                     a_explore_q, a_explore_d;
    logic [DATA_WIDTH-1:0]    b_qmax_q, b_qmax_d;
    logic [15:0]              lfsr_q;
    logic                     lfsr_fb;

    logic                     gnt_a, gnt_b, mx_valid, done_a, done_b, explore;
    logic [ACTIONS_WIDTH-1:0] act_sel;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign explore = lfsr_q[7:0] < bus.epsilon;
    assign act_sel = explore ? lfsr_q[8 +: ACTIONS_WIDTH] : res_idx_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        mx_data_d     = mx_data_q;
        timer_d       = timer_q;
        res_max_d     = res_max_q;
        res_idx_d     = res_idx_q;
        timeout_err_d = timeout_err_q;
        a_action_d    = a_action_q;
        a_explore_d   = a_explore_q;
        b_qmax_d      = b_qmax_q;
        gnt_a         = 1'b0;
        gnt_b         = 1'b0;
        mx_valid      = 1'b0;
        done_a        = 1'b0;
        done_b        = 1'b0;
        unique case (state_q)
            StIdle: begin
                gnt_a = bus.a_req & (~bus.b_req | rr_last_q);
                gnt_b = bus.b_req & ~gnt_a;
                if (gnt_a || gnt_b) begin
                    owner_d   = gnt_b;
                    rr_last_d = gnt_b;
                    mx_data_d = gnt_b ? bus.b_data : bus.a_data;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                mx_valid = 1'b1;
                timer_d  = '0;
                state_d  = StWait;
            end
            StWait: begin
                if (bus.mx_done) begin
                    res_max_d = bus.mx_max;
                    res_idx_d = bus.mx_at_max;
                    state_d   = StResp;
                end else if (timer_q == TimerLast) begin
                    timeout_err_d = 1'b1;
                    res_max_d     = '0;
                    res_idx_d     = '0;
                    state_d       = StResp;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StResp: begin
                if (owner_q) begin
                    done_b   = 1'b1;
                    b_qmax_d = res_max_q;
                end else begin
                    done_a      = 1'b1;
                    a_explore_d = explore;
                    a_action_d  = act_sel;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b1;
            mx_data_q     <= '0;
            timer_q       <= '0;
            res_max_q     <= '0;
            res_idx_q     <= '0;
            timeout_err_q <= 1'b0;
            a_action_q    <= '0;
            a_explore_q   <= 1'b0;
            b_qmax_q      <= '0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            mx_data_q     <= mx_data_d;
            timer_q       <= timer_d;
            res_max_q     <= res_max_d;
            res_idx_q     <= res_idx_d;
            timeout_err_q <= timeout_err_d;
            a_action_q    <= a_action_d;
            a_explore_q   <= a_explore_d;
            b_qmax_q      <= b_qmax_d;
            lfsr_q        <= {lfsr_fb, lfsr_q[15:1]};
        end
    end

    // Pulses are masked while reset is held so a stale state cannot leak out.
    assign bus.a_gnt       = gnt_a & rst_ni;
    assign bus.b_gnt       = gnt_b & rst_ni;
    assign bus.mx_valid    = mx_valid & rst_ni;
    assign bus.a_done      = done_a & rst_ni;
    assign bus.b_done      = done_b & rst_ni;
    assign bus.mx_data     = mx_data_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.a_action    = done_a ? act_sel : a_action_q;
    assign bus.a_explore   = done_a ? explore : a_explore_q;
    assign bus.b_qmax      = done_b ? res_max_q : b_qmax_q;
endmodule
